floor_controller: RTL and testbench
===================================

// Module: floor_controller
// PURPOSE
//  Consumes the move_clk tick stream from frequency_move and runs a 3-floor car.
//  Latches hall/cab requests (button1..3), picks a travel direction and steps
//  current_floor by one per tick. Opens the door at requested floors, and returns
//  `moving` to frequency_move. Also honours sos_mode and weight_limit_exceeded.
// PARAMETERS
//  DOOR_TICKS  3  move_clk rising edges the door stays open (>=1)
//  HOME_FLOOR  0  floor index loaded at reset (0..2)
// PORTS
//  clk                    in   1  system clock; all logic on posedge
//  rst                    in   1  synchronous, active-high reset
//  move_clk               in   1  step tick from frequency_move; rising edge = 1 tick
//  button1                in   1  request floor 0, active-low, already debounced
//  button2                in   1  request floor 1, active-low
//  button3                in   1  request floor 2, active-low
//  sos_mode               in   1  emergency stop, level
//  weight_limit_exceeded  in   1  overload, level
//  current_floor          out  2  floor index 0..2; value 3 never driven
//  direction              out  1  1=up, 0=down; valid when moving=1
//  moving                 out  1  1 while state=MOVE
//  door_open              out  1  1 while state=DOOR
//  pending                out  3  latched requests, bit i = floor i
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, current_floor=HOME_FLOOR, direction=1,
//   moving=0, door_open=0, pending=0, door counter=0, move_clk_q=0. rst overrides all.
//  tick = move_clk & ~move_clk_q; move_clk_q is a 1-cycle delayed copy.
//   Only ticks advance the floor or the door timer.
//  Request latch: button(i)=0 sampled at posedge sets pending[i] next cycle.
//   Exceptions:
//   - sos_mode=1: presses are ignored.
//   - Floor i == current_floor while state is DOOR or IDLE: pending[i] is not set.
//     DOOR restarts the door counter instead; IDLE goes to DOOR.
//   A held button sets the bit again on every cycle; this is harmless.
//  FSM states: IDLE, MOVE, DOOR. All outputs are registered.
//  IDLE:
//   - sos_mode=1 -> DOOR.
//   - Press/pending at current_floor -> DOOR; that bit is cleared.
//   - Else weight_limit_exceeded=1 -> stay in IDLE.
//   - Else pending above -> MOVE, direction=1.
//   - Else pending below -> MOVE, direction=0.
//   - Up has priority when both exist.
//  MOVE:
//   - sos_mode=1 -> DOOR at current_floor (car is stopped at a floor); pending cleared.
//   - On tick: current_floor += direction ? +1 : -1.
//     - If pending[new floor] -> DOOR; bit cleared.
//     - Else if more pending in direction -> stay in MOVE.
//     - Else if pending opposite -> flip direction, stay in MOVE.
//     - Else -> IDLE.
//   - Never steps past floor 2 going up or below floor 0 going down; the above
//     rules guarantee this, and an assertion checks it.
//  DOOR:
//   - Entry clears the counter. Each tick increments it.
//   - Counter==DOOR_TICKS with sos_mode=0 and weight_limit_exceeded=0 -> IDLE.
//   - While sos_mode or weight_limit_exceeded is high, the counter is held at
//     DOOR_TICKS max and the state stays DOOR.
//   - sos_mode=1 also holds pending=0.
//  Simultaneous events:
//   - tick and press for the same new floor in one cycle: open the door, bit ends cleared.
//   - sos_mode and tick in one cycle: sos wins, no floor step.
//  Latency: press -> pending 1 cycle; tick -> current_floor update 1 cycle;
//   arrival -> door_open 1 cycle (same edge as the floor update).
// TESTING
//  1 Reset, HOME_FLOOR=0; button3 low 1 cycle.
//    -> pending=3'b100, moving=1, dir=1. Floor 0->1->2 on successive ticks.
//    Door opens at floor 2, pending=0. IDLE after 3 ticks.
//  2 At floor 0, press button2 and button3.
//    -> stop at 1 (door 3 ticks, bit1 cleared), continue to 2, then IDLE.
//  3 At floor 2 moving down to 0, press button3 mid-trip.
//    -> reach 0, door, then reverse dir=0->1, travel to 2.
//  4 In DOOR at floor 1, hold weight_limit_exceeded=1 for 10 ticks.
//    -> door_open stays 1, no departure. Release -> IDLE on next tick.
//  5 In MOVE between ticks, sos_mode=1.
//    -> next cycle DOOR, pending=0, moving=0. Presses ignored.
//    Release -> closes after DOOR_TICKS ticks.
//  6 rst pulsed mid-MOVE at floor 1.
//    -> next cycle floor=HOME_FLOOR, IDLE, all outputs 0 except direction=1.

Source files
------------

// File: rtl/floor_controller.sv
// Three-floor car controller: latches requests, steps one floor per move_clk tick,
// times the door in ticks and honours emergency stop and overload.
module floor_controller #(
   parameter int DOOR_TICKS = 3,
   parameter int HOME_FLOOR = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       move_clk,
   input  logic       button1,
   input  logic       button2,
   input  logic       button3,
   input  logic       sos_mode,
   input  logic       weight_limit_exceeded,
   output logic [1:0] current_floor,
   output logic       direction,
   output logic       moving,
   output logic       door_open,
   output logic [2:0] pending
);

   // state  | meaning
   // S_IDLE | parked with the door shut, waiting for a request
   // S_MOVE | travelling, one floor per move_clk tick
   // S_DOOR | door open at current_floor, timed in ticks
   typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

   localparam int            CW      = $clog2(DOOR_TICKS + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DOOR_TICKS);

   state_t        state, state_n;
   logic [1:0]    floor_n;
   logic          dir_n;
   logic [2:0]    pend_n;
   logic [CW-1:0] door_cnt, cnt_n;
   logic          move_clk_q;

   logic          tick;
   logic [2:0]    req, pend_set, cur_mask, nf_mask;
   logic [1:0]    nf;

   function automatic logic [2:0] onehot(input logic [1:0] f);
      return 3'b001 << f;
   endfunction

   function automatic logic [2:0] above(input logic [1:0] f);
      case (f)
         2'd0:    return 3'b110;
         2'd1:    return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   function automatic logic [2:0] below(input logic [1:0] f);
      case (f)
         2'd1:    return 3'b001;
         2'd2:    return 3'b011;
         default: return 3'b000;
      endcase
   endfunction

   assign tick      = move_clk & ~move_clk_q;
   assign req       = sos_mode ? 3'b000 : ~{button3, button2, button1};
   assign pend_set  = pending | req;
   assign cur_mask  = onehot(current_floor);
   assign nf        = direction ? current_floor + 2'd1 : current_floor - 2'd1;
   assign nf_mask   = onehot(nf);
   assign moving    = (state == S_MOVE);
   assign door_open = (state == S_DOOR);

   always_comb begin
      state_n = state;
      floor_n = current_floor;
      dir_n   = direction;
      pend_n  = pending;
      cnt_n   = door_cnt;
      case (state)
         S_IDLE: begin
            if (sos_mode) begin
               state_n = S_DOOR;
               pend_n  = 3'b000;
               cnt_n   = '0;
            end else if (|(pend_set & cur_mask)) begin
               state_n = S_DOOR;
               pend_n  = pend_set & ~cur_mask;
               cnt_n   = '0;
            end else begin
               pend_n = pend_set;
               if (!weight_limit_exceeded) begin
                  if (|(pend_set & above(current_floor))) begin
                     state_n = S_MOVE;
                     dir_n   = 1'b1;
                  end else if (|(pend_set & below(current_floor))) begin
                     state_n = S_MOVE;
                     dir_n   = 1'b0;
                  end
               end
            end
         end
         S_MOVE: begin
            if (sos_mode) begin
               // emergency stop wins over a coincident tick: no floor step
               state_n = S_DOOR;
               pend_n  = 3'b000;
               cnt_n   = '0;
            end else begin
               pend_n = pend_set;
               if (tick) begin
                  floor_n = nf;
                  if (|(pend_set & nf_mask)) begin
                     state_n = S_DOOR;
                     pend_n  = pend_set & ~nf_mask;
                     cnt_n   = '0;
                  end else if (direction ? |(pend_set & above(nf))
                                         : |(pend_set & below(nf))) begin
                     state_n = S_MOVE;
                  end else if (direction ? |(pend_set & below(nf))
                                         : |(pend_set & above(nf))) begin
                     dir_n = ~direction;
                  end else begin
                     state_n = S_IDLE;
                  end
               end
            end
         end
         S_DOOR: begin
            pend_n = sos_mode ? 3'b000 : (pend_set & ~cur_mask);
            if (tick) begin
               if (sos_mode || weight_limit_exceeded)
                  cnt_n = (door_cnt == CNT_MAX) ? door_cnt : door_cnt + 1'b1;
               else if (int'(door_cnt) + 1 >= DOOR_TICKS)
                  state_n = S_IDLE;
               else
                  cnt_n = door_cnt + 1'b1;
            end
            // a press for this floor keeps the door open for a fresh period
            if (|(req & cur_mask)) begin
               state_n = S_DOOR;
               cnt_n   = '0;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         current_floor <= 2'(HOME_FLOOR);
         direction     <= 1'b1;
         pending       <= 3'b000;
         door_cnt      <= '0;
         move_clk_q    <= 1'b0;
      end else begin
         state         <= state_n;
         current_floor <= floor_n;
         direction     <= dir_n;
         pending       <= pend_n;
         door_cnt      <= cnt_n;
         move_clk_q    <= move_clk;
      end
   end

   a_floor_range: assert property (@(posedge clk) disable iff (rst)
      (current_floor != 2'd3) &&
      !(state == S_MOVE && direction && current_floor == 2'd2) &&
      !(state == S_MOVE && !direction && current_floor == 2'd0));

endmodule

// File: tb/tb_floor_controller.sv
// Directed bench for floor_controller (DOOR_TICKS=3, HOME_FLOOR=0).
module tb_floor_controller;

   logic       clk = 1'b0;
   logic       rst, move_clk, sos_mode, weight_limit_exceeded;
   logic [2:0] btn;
   logic [1:0] current_floor;
   logic       direction, moving, door_open;
   logic [2:0] pending;

   int n_tests = 0;
   int n_fail  = 0;

   floor_controller #(.DOOR_TICKS(3), .HOME_FLOOR(0)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .move_clk              (move_clk),
      .button1               (btn[0]),
      .button2               (btn[1]),
      .button3               (btn[2]),
      .sos_mode              (sos_mode),
      .weight_limit_exceeded (weight_limit_exceeded),
      .current_floor         (current_floor),
      .direction             (direction),
      .moving                (moving),
      .door_open             (door_open),
      .pending               (pending)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      move_clk = 1'b1;
      @(negedge clk);
      move_clk = 1'b0;
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // floors given as a mask, bit i = floor i, held low for one cycle
   task automatic press(input logic [2:0] floors);
      btn = ~floors;
      @(negedge clk);
      btn = 3'b111;
   endtask

   initial begin
      rst = 1'b1; move_clk = 1'b0; sos_mode = 1'b0;
      weight_limit_exceeded = 1'b0; btn = 3'b111;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_floor",   8'(current_floor), 8'd0);
      check("rst_dir",     8'(direction),     8'd1);
      check("rst_moving",  8'(moving),        8'd0);
      check("rst_door",    8'(door_open),     8'd0);
      check("rst_pending", 8'(pending),       8'd0);

      // press at the parked floor opens the door without latching a request
      press(3'b001);
      check("here_door",    8'(door_open), 8'd1);
      check("here_pending", 8'(pending),   8'd0);
      ticks(3);
      check("here_close",   8'(door_open), 8'd0);

      // 0 -> 2 on one request
      press(3'b100);
      check("t1_pending", 8'(pending),   8'd4);
      check("t1_moving",  8'(moving),    8'd1);
      check("t1_dir",     8'(direction), 8'd1);
      tick();
      check("t1_floor1",  8'(current_floor), 8'd1);
      check("t1_moving1", 8'(moving),        8'd1);
      tick();
      check("t1_floor2",  8'(current_floor), 8'd2);
      check("t1_door",    8'(door_open),     8'd1);
      check("t1_pend0",   8'(pending),       8'd0);
      ticks(2);
      check("t1_door_t2", 8'(door_open), 8'd1);
      tick();
      check("t1_idle",    8'(door_open), 8'd0);
      check("t1_idle_mv", 8'(moving),    8'd0);

      // down to 0 with a request for 2 made mid-trip, then reverse
      press(3'b001);
      check("t3_dir_dn", 8'(direction), 8'd0);
      tick();
      check("t3_floor1", 8'(current_floor), 8'd1);
      press(3'b100);
      check("t3_pend",   8'(pending), 8'd5);
      tick();
      check("t3_floor0", 8'(current_floor), 8'd0);
      check("t3_door",   8'(door_open),     8'd1);
      check("t3_pend4",  8'(pending),       8'd4);
      ticks(3);
      check("t3_rev_mv",  8'(moving),    8'd1);
      check("t3_rev_dir", 8'(direction), 8'd1);
      ticks(2);
      check("t3_floor2", 8'(current_floor), 8'd2);
      check("t3_door2",  8'(door_open),     8'd1);
      ticks(3);

      // return to 0, then an intermediate stop at 1 on the way to 2
      press(3'b001);
      ticks(2);
      check("t2_at0", 8'(current_floor), 8'd0);
      ticks(3);
      press(3'b110);
      check("t2_pend",   8'(pending), 8'd6);
      tick();
      check("t2_floor1", 8'(current_floor), 8'd1);
      check("t2_door1",  8'(door_open),     8'd1);
      check("t2_pend4",  8'(pending),       8'd4);
      ticks(3);
      check("t2_resume", 8'(moving), 8'd1);
      tick();
      check("t2_floor2", 8'(current_floor), 8'd2);
      check("t2_door2",  8'(door_open),     8'd1);
      check("t2_pend0",  8'(pending),       8'd0);
      ticks(3);
      check("t2_idle", 8'(door_open), 8'd0);

      // overload holds the door at floor 1
      press(3'b010);
      tick();
      check("t4_door", 8'(door_open), 8'd1);
      weight_limit_exceeded = 1'b1;
      ticks(10);
      check("t4_held",  8'(door_open),     8'd1);
      check("t4_floor", 8'(current_floor), 8'd1);
      weight_limit_exceeded = 1'b0;
      @(negedge clk);
      check("t4_wait_tick", 8'(door_open), 8'd1);
      tick();
      check("t4_close", 8'(door_open), 8'd0);
      check("t4_still", 8'(moving),    8'd0);

      // emergency stop coinciding with a tick mid-move
      press(3'b100);
      check("t5_moving", 8'(moving), 8'd1);
      sos_mode = 1'b1;
      move_clk = 1'b1;
      @(negedge clk);
      move_clk = 1'b0;
      check("t5_door",    8'(door_open),     8'd1);
      check("t5_moving0", 8'(moving),        8'd0);
      check("t5_pend0",   8'(pending),       8'd0);
      check("t5_nostep",  8'(current_floor), 8'd1);
      press(3'b001);
      check("t5_ignore",  8'(pending), 8'd0);
      @(negedge clk);
      sos_mode = 1'b0;
      ticks(2);
      check("t5_open2", 8'(door_open), 8'd1);
      tick();
      check("t5_close", 8'(door_open), 8'd0);

      // reset in the middle of a move
      press(3'b100);
      check("t6_moving", 8'(moving), 8'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t6_floor",  8'(current_floor), 8'd0);
      check("t6_moving0",8'(moving),        8'd0);
      check("t6_door",   8'(door_open),     8'd0);
      check("t6_pend",   8'(pending),       8'd0);
      check("t6_dir",    8'(direction),     8'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: run did not complete, expected finish");
      $fatal(1);
   end

endmodule
